ps2_scancode_rx: RTL
====================

Name: ps2_scancode_rx

Overview:
- Receives PS/2 keyboard frames on the raw ps2_clk/ps2_data pins and deserialises them into scan-code bytes.
- Strips the F0 break prefix and the E0 extended prefix.
- Presents each key press as a one-cycle, nonzero 8-bit strobe on key; downstream keyboard consumers (octave/note selectors) act on any cycle where key != 0.
- Sits between the board PS/2 pins and all key-driven control blocks.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples required before the filtered ps2_clk changes level.
- TIMEOUT_CYC, 200000: clk cycles without a filtered ps2_clk falling edge, mid-frame, before the frame is aborted.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- key  out  8  make code; nonzero for exactly one cycle per make event, 0 otherwise.
- key_ext  out  1  high together with key when the make code was E0-prefixed.
- rel  out  8  break code; nonzero for one cycle per release event, 0 otherwise.
- rel_ext  out  1  high together with rel when the release was E0-prefixed.
- err  out  1  one-cycle pulse on parity error, bad start/stop bit or timeout.

Behaviour:
- Reset (rst_n low at a clk edge) sets:
  - key=0, key_ext=0, rel=0, rel_ext=0, err=0;
  - state=IDLE; brk_flag=0; ext_flag=0;
  - bit counter, timeout counter and filter counter = 0;
  - filtered clk = 1.
  - A frame in progress when reset is applied is discarded.
- Input conditioning:
  - 2-FF synchroniser on each pin.
  - Filtered clk copies the synchronised clk only after FILTER_LEN equal consecutive samples; shorter glitches are ignored.
  - Data is sampled from the synchronised data in the cycle the filtered clk goes 1->0 ("edge").
- FSM, advancing on edges only:
  - IDLE: sampled 0 -> DATA with bitcnt=0. Sampled 1 -> stay IDLE and pulse err.
  - DATA: shift in LSB first; after the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: check stop=1 and odd parity over the 8 data bits plus the parity bit -> IDLE.
- Timeout:
  - Counter clears on every edge and while in IDLE.
  - In DATA/PARITY/STOP, reaching TIMEOUT_CYC forces IDLE, pulses err, and clears brk_flag/ext_flag.
- Frame evaluation (edge in STOP at cycle N; outputs registered, valid at N+1 for exactly one cycle):
  - Bad parity or stop bit: err=1; byte dropped; brk_flag/ext_flag cleared.
  - Byte E0: ext_flag=1, no output.
  - Byte F0: brk_flag=1, no output.
  - Byte 00 (keyboard overrun): err=1, flags cleared.
  - Other byte with brk_flag=1: rel=byte, rel_ext=ext_flag; both flags cleared.
  - Other byte with brk_flag=0: key=byte, key_ext=ext_flag; ext_flag cleared.
- Typematic repeats (repeated make codes) each produce a fresh key strobe; no suppression.
- key and rel are never nonzero in the same cycle; err never coincides with a key or rel strobe.
- Outputs return to 0 the cycle after any strobe.
- Back-to-back frames need no idle gap beyond the stop bit.

Test Plan:
- Frame 0x1C (start 0, data LSB first, parity 0, stop 1) with 40 us bit period at 100 MHz -> key=0x1C, key_ext=0 for exactly one cycle, one cycle after the stop-bit edge; rel=0, err=0 throughout.
- Frames F0, 1C -> no key strobe; rel=0x1C, rel_ext=0 for one cycle; next frame 1C -> key=0x1C.
- Frames E0, 75 -> key=0x75, key_ext=1. Then E0, F0, 75 -> rel=0x75, rel_ext=1. Then 1C -> key_ext=0.
- Frame 0x1C with parity bit inverted -> err one cycle, key stays 0; following good frame 0x12 -> key=0x12.
- Stop after 4 data bits, idle TIMEOUT_CYC+10 cycles -> err one cycle, FSM in IDLE; next full frame 0x59 -> key=0x59.
- ps2_clk low glitch of FILTER_LEN-2 cycles mid-bit -> no extra bit shifted, frame decodes correctly.
- rst_n low for 1 cycle after 5 bits, then a full frame 0x1C -> only key=0x1C is produced; no err.

Source files
------------

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: conditions the raw pins, deserialises 11-bit frames and
// turns E0/F0-prefixed scan codes into one-cycle make/break strobes.
module ps2_scancode_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key,
    output logic       key_ext,
    output logic [7:0] rel,
    output logic       rel_ext,
    output logic       err
);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt;
    logic [FW-1:0] fcnt;
    logic          fall;
    state_t        state;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          par;
    logic          brk_flag, ext_flag;
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {clk_s1, clk_s2} <= 2'b11;
            {dat_s1, dat_s2} <= 2'b11;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // The filtered clock only follows after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt <= 1'b1;
            fcnt <= '0;
        end else if (clk_s2 == filt) begin
            fcnt <= '0;
        end else if (fcnt == FMAX) begin
            filt <= clk_s2;
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + 1'b1;
        end
    end

    assign fall = filt && !clk_s2 && (fcnt == FMAX);

    // Payload capture carries no reset; a restarted frame overwrites it anyway.
    always_ff @(posedge clk) begin
        if (fall && state == DATA)   shreg <= {dat_s2, shreg[7:1]};
        if (fall && state == PARITY) par   <= dat_s2;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            bitcnt   <= '0;
            brk_flag <= 1'b0;
            ext_flag <= 1'b0;
            tcnt     <= '0;
            key      <= '0;
            key_ext  <= 1'b0;
            rel      <= '0;
            rel_ext  <= 1'b0;
            err      <= 1'b0;
        end else begin
            key     <= '0;
            key_ext <= 1'b0;
            rel     <= '0;
            rel_ext <= 1'b0;
            err     <= 1'b0;

            if (state == IDLE || fall) tcnt <= '0;
            else                       tcnt <= tcnt + 1'b1;

            if (state != IDLE && !fall && tcnt == TMAX) begin
                state    <= IDLE;
                err      <= 1'b1;
                brk_flag <= 1'b0;
                ext_flag <= 1'b0;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        if (!dat_s2) begin
                            state  <= DATA;
                            bitcnt <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    DATA: begin
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'd7) state <= PARITY;
                    end
                    PARITY: state <= STOP;
                    STOP: begin
                        state <= IDLE;
                        // Odd parity: data plus parity bit must hold an odd number of ones.
                        if (!dat_s2 || !(^{shreg, par})) begin
                            err      <= 1'b1;
                            brk_flag <= 1'b0;
                            ext_flag <= 1'b0;
                        end else if (shreg == 8'hE0) begin
                            ext_flag <= 1'b1;
                        end else if (shreg == 8'hF0) begin
                            brk_flag <= 1'b1;
                        end else if (shreg == 8'h00) begin
                            err      <= 1'b1;
                            brk_flag <= 1'b0;
                            ext_flag <= 1'b0;
                        end else if (brk_flag) begin
                            rel      <= shreg;
                            rel_ext  <= ext_flag;
                            brk_flag <= 1'b0;
                            ext_flag <= 1'b0;
                        end else begin
                            key      <= shreg;
                            key_ext  <= ext_flag;
                            ext_flag <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
